round_const_inv: RTL and testbench

- Decryption-side round-constant sequencer for the LOONG datapath; counterpart to the encryption-side round-constant generator.
- Runs the 6-bit round-constant LFSR backwards. It emits the round-constant nibble matrix for rounds NUM_ROUNDS-1 down to 0 over a valid/ready handshake.
- Sits between the decryption control FSM and the inverse AddRoundConstant stage.

---
 rtl/round_const_inv.sv | 177 +++++++++++++++++
 tb/tb_round_const_inv.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/round_const_inv.sv
// rtl/round_const_inv.sv - LOONG decryption-side round-constant sequencer (inverse LFSR)
//
// Walks the 6-bit round-constant LFSR backwards from LAST_RC and emits the
// round-constant nibble matrix for rounds NUM_ROUNDS-1 down to 0, one matrix
// per valid/ready transfer.
//
// Ports:
//   clock      in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   begin a sequence (only honoured in IDLE)
//   rc_ready   in   consumer accepts the current matrix
//   round_cnst out  [0:3][0:3] x 4-bit round-constant matrix for round j_out
//   rc_valid   out  round_cnst / j_out are valid
//   j_out      out  round index of the current matrix
//   busy       out  high in every state except IDLE
//   seq_done   out  one-cycle pulse after the round-0 transfer
//   rc_err     out  sticky self-check error flag
//
// Optional build macro: RCINV_SELFCHECK_EN enables the end-of-sequence
// self-check; without it rc_err is tied low.

module round_const_inv #(
  parameter int          NUM_ROUNDS = 33,
  parameter logic [5:0]  LAST_RC    = 6'h31
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic       rc_ready,
  output logic [3:0] round_cnst [0:3][0:3],
  output logic       rc_valid,
  output logic [5:0] j_out,
  output logic       busy,
  output logic       seq_done,
  output logic       rc_err
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  localparam logic [5:0] LAST_J = 6'(NUM_ROUNDS - 1);

  state_t     state_q, state_d;
  logic [5:0] rc_q, rc_d;
  logic [5:0] j_q, j_d;
  logic       valid_q, valid_d;
  logic [3:0] mat_q [0:3][0:3];
  logic [3:0] mat_d [0:3][0:3];
  logic       load;
  logic       xfer;
  logic       last_xfer;

  // Undo one forward step n = {rc[4:0], rc[5]^rc[4]^1}.
  function automatic logic [5:0] rc_prev(input logic [5:0] n);
    return {n[0] ^ n[5] ^ 1'b1, n[5:1]};
  endfunction

  assign xfer      = (state_q == EMIT) && valid_q && rc_ready;
  assign last_xfer = xfer && (j_q == 6'd0);

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EMIT;
      EMIT:    if (last_xfer) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = (state_q != IDLE);
    seq_done = (state_q == DONE);
  end

  // Datapath next values
  always_comb begin
    rc_d    = rc_q;
    j_d     = j_q;
    valid_d = valid_q;
    load    = 1'b0;
    if ((state_q == IDLE) && start) begin
      rc_d    = LAST_RC;
      j_d     = LAST_J;
      valid_d = 1'b1;
      load    = 1'b1;
    end else if (xfer) begin
      if (j_q != 6'd0) begin
        rc_d = rc_prev(rc_q);
        j_d  = j_q - 6'd1;
        load = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // The matrix is mapped from the incoming rc so it lines up with rc_q; it is
  // only rewritten on a load, so DONE keeps the last matrix and reset leaves
  // it all-zero rather than the mapping of rc=0.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        mat_d[r][c] = load ? 4'd0 : mat_q[r][c];
      end
    end
    if (load) begin
      mat_d[0][3] = {3'b000, |rc_d[5:3]};
      mat_d[1][3] = {3'b000, |rc_d[2:0]};
      mat_d[2][3] = {3'b000, |rc_d[5:3]};
      mat_d[3][3] = {3'b000, |rc_d[2:0]};
      mat_d[1][2] = 4'd1;
      mat_d[2][2] = 4'd2;
      mat_d[3][2] = 4'd4;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rc_q    <= 6'd0;
      j_q     <= 6'd0;
      valid_q <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          mat_q[r][c] <= 4'd0;
        end
      end
    end else begin
      rc_q    <= rc_d;
      j_q     <= j_d;
      valid_q <= valid_d;
      mat_q   <= mat_d;
    end
  end

  assign rc_valid   = valid_q;
  assign j_out      = j_q;
  assign round_cnst = mat_q;

`ifdef RCINV_SELFCHECK_EN
  logic [6:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // Count transfers of the current sequence; on the round-0 transfer the
  // final rc must be the round-0 constant and the count must be complete.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if ((state_q == IDLE) && start) cnt_d = 7'd0;
    else if (xfer)                  cnt_d = cnt_q + 7'd1;
    if (last_xfer && ((rc_q != 6'h01) || (cnt_q + 7'd1 != 7'(NUM_ROUNDS))))
      err_d = 1'b1;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q <= 7'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rc_err = err_q;
`else
  assign rc_err = 1'b0;
`endif

endmodule

// File: tb/tb_round_const_inv.sv
// tb/tb_round_const_inv.sv - scoreboard bench for round_const_inv
module tb_round_const_inv;

  logic       clock;
  logic       rst;
  logic       start;
  logic       rc_ready;
  logic [3:0] round_cnst [0:3][0:3];
  logic       rc_valid;
  logic [5:0] j_out;
  logic       busy;
  logic       seq_done;
  logic       rc_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [5:0] j;
    logic [5:0] rc;
  } exp_t;

  exp_t       sb [$];
  logic [5:0] fwd [0:32];

  round_const_inv dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .rc_ready   (rc_ready),
    .round_cnst (round_cnst),
    .rc_valid   (rc_valid),
    .j_out      (j_out),
    .busy       (busy),
    .seq_done   (seq_done),
    .rc_err     (rc_err)
  );

`ifdef RCINV_SELFCHECK_EN
  logic [3:0] round_cnst2 [0:3][0:3];
  logic       rc_valid2, busy2, seq_done2, rc_err2;
  logic [5:0] j_out2;

  round_const_inv #(.NUM_ROUNDS(33), .LAST_RC(6'h30)) dut2 (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .rc_ready   (rc_ready),
    .round_cnst (round_cnst2),
    .rc_valid   (rc_valid2),
    .j_out      (j_out2),
    .busy       (busy2),
    .seq_done   (seq_done2),
    .rc_err     (rc_err2)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_mat(input logic [5:0] rc);
    logic [63:0] m;
    m = '0;
    m[3*4  +: 4] = {3'b000, |rc[5:3]};
    m[7*4  +: 4] = {3'b000, |rc[2:0]};
    m[11*4 +: 4] = {3'b000, |rc[5:3]};
    m[15*4 +: 4] = {3'b000, |rc[2:0]};
    m[6*4  +: 4] = 4'd1;
    m[10*4 +: 4] = 4'd2;
    m[14*4 +: 4] = 4'd4;
    return m;
  endfunction

  function automatic logic [63:0] obs_mat();
    logic [63:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[(r*4+c)*4 +: 4] = round_cnst[r][c];
    return m;
  endfunction

  task automatic check_entry(input string tag, input exp_t e);
    chk({tag, "_valid"}, 64'(rc_valid), 64'd1);
    chk({tag, "_j"},     64'(j_out),    64'(e.j));
    chk({tag, "_rc"},    64'(dut.rc_q), 64'(e.rc));
    chk({tag, "_mat"},   obs_mat(),     exp_mat(e.rc));
    chk({tag, "_busy"},  64'(busy),     64'd1);
    chk({tag, "_done"},  64'(seq_done), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 64'(rc_valid), 64'd0);
    chk({tag, "_j"},     64'(j_out),    64'd0);
    chk({tag, "_mat"},   obs_mat(),     64'd0);
    chk({tag, "_busy"},  64'(busy),     64'd0);
    chk({tag, "_done"},  64'(seq_done), 64'd0);
    chk({tag, "_err"},   64'(rc_err),   64'd0);
`ifdef RCINV_SELFCHECK_EN
    chk({tag, "_err2"},  64'(rc_err2),  64'd0);
`endif
  endtask

  // mode 1 = random rc_ready; stall_j/start_j/rst_j = -1 disables that event
  task automatic run_seq(input string tag, input int mode, input int stall_j,
                         input int start_j, input int rst_j);
    exp_t e;
    int   cycles;
    bit   stalled;
    stalled = 0;
    cycles  = 0;
    for (int j = 32; j >= 0; j--) sb.push_back('{j: 6'(j), rc: fwd[j]});
    start    = 1'b1;
    rc_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    while (sb.size() > 0 && cycles < 300) begin
      e = sb[0];
      check_entry(tag, e);
      if (int'(e.j) == rst_j) begin
        #2 rst = 1'b1;
        #1 check_reset({tag, "_async_rst"});
        sb.delete();
        @(negedge clock);
        rst = 1'b0;
        return;
      end
      if (int'(e.j) == stall_j && !stalled) begin
        rc_ready = 1'b0;
        repeat (3) begin
          @(negedge clock);
          check_entry({tag, "_stall"}, e);
        end
        stalled = 1;
      end
      rc_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = (int'(e.j) == start_j);
      @(negedge clock);
      start = 1'b0;
      if (rc_ready) void'(sb.pop_front());
      cycles++;
    end
    chk({tag, "_timeout"}, 64'(sb.size()), 64'd0);
    chk({tag, "_done_pulse"}, 64'(seq_done), 64'd1);
    chk({tag, "_done_busy"},  64'(busy),     64'd1);
    chk({tag, "_done_valid"}, 64'(rc_valid), 64'd0);
    chk({tag, "_done_j"},     64'(j_out),    64'd0);
    chk({tag, "_done_mat"},   obs_mat(),     exp_mat(6'h01));
    chk({tag, "_done_err"},   64'(rc_err),   64'd0);
`ifdef RCINV_SELFCHECK_EN
    chk({tag, "_done_err2"},  64'(rc_err2),  64'd1);
`endif
    // start while in DONE must be ignored
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk({tag, "_idle_done"},  64'(seq_done), 64'd0);
    chk({tag, "_idle_busy"},  64'(busy),     64'd0);
    chk({tag, "_idle_valid"}, 64'(rc_valid), 64'd0);
    @(negedge clock);
    chk({tag, "_idle_busy2"}, 64'(busy),     64'd0);
`ifdef RCINV_SELFCHECK_EN
    chk({tag, "_sticky_err2"}, 64'(rc_err2), 64'd1);
`endif
  endtask

  initial begin
    // Expected constants: forward LFSR from the round-0 value 0x01.
    fwd[0] = 6'h01;
    for (int i = 1; i <= 32; i++)
      fwd[i] = {fwd[i-1][4:0], fwd[i-1][5] ^ fwd[i-1][4] ^ 1'b1};

    rst      = 1'b1;
    start    = 1'b0;
    rc_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clock);
    check_reset("post_reset");

    run_seq("full",    0, -1, -1, -1);
    run_seq("stall",   0, 20, 10,  5);
    run_seq("restart", 0, -1, -1, -1);
    run_seq("rand",    1, -1, -1, -1);
    run_seq("stall2",  1, 20, 10, -1);

    rst = 1'b1;
    @(negedge clock);
    check_reset("final_reset");
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
